// File: rtl/cswap_checker.sv
// Response checker for a 3-bit Fredkin (controlled-swap) gate: counts vectors and mismatches,
// tracks input coverage. Optional per-combination error mask under CSWAP_CHK_ERRMASK_EN.
module cswap_checker #(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned STOP_ON_ERR = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  input  logic             a,
  input  logic             b,
  input  logic             c,
  input  logic             a1,
  input  logic             b1,
  input  logic             c1,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             err_flag,
  output logic [CNT_W-1:0] vec_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [7:0]       cov_mask,
`ifdef CSWAP_CHK_ERRMASK_EN
  output logic [7:0]       err_mask,
`endif
  output logic [5:0]       first_err
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic             err_flag_q, err_flag_d;
  logic [CNT_W-1:0] vec_cnt_q, vec_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [7:0]       cov_mask_q, cov_mask_d;
  logic [5:0]       first_err_q, first_err_d;
`ifdef CSWAP_CHK_ERRMASK_EN
  logic [7:0]       err_mask_q, err_mask_d;
`endif

  logic       clear;
  logic       accept;
  logic [2:0] exp_out;
  logic       mismatch;
  logic [7:0] combo_hot;

  // Fredkin reference: A passes through, B/C swap when A is set.
  assign exp_out   = a ? {1'b1, c, b} : {1'b0, b, c};
  assign mismatch  = ({a1, b1, c1} != exp_out);
  assign combo_hot = 8'd1 << {a, b, c};

  always_comb begin
    state_d     = state_q;
    vec_cnt_d   = vec_cnt_q;
    err_cnt_d   = err_cnt_q;
    err_flag_d  = err_flag_q;
    cov_mask_d  = cov_mask_q;
    first_err_d = first_err_q;
`ifdef CSWAP_CHK_ERRMASK_EN
    err_mask_d  = err_mask_q;
`endif
    clear       = 1'b0;
    accept      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          clear   = 1'b1;
        end
      end
      ST_RUN: begin
        accept = in_valid;
      end
      ST_DONE: begin
        if (start) begin
          state_d = ST_RUN;
          clear   = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (clear) begin
      vec_cnt_d   = '0;
      err_cnt_d   = '0;
      err_flag_d  = 1'b0;
      cov_mask_d  = '0;
      first_err_d = '0;
`ifdef CSWAP_CHK_ERRMASK_EN
      err_mask_d  = '0;
`endif
    end else if (accept) begin
      if (vec_cnt_q != '1) begin
        vec_cnt_d = vec_cnt_q + CNT_W'(1);
      end
      cov_mask_d = cov_mask_q | combo_hot;
      if (mismatch) begin
        if (err_cnt_q != '1) begin
          err_cnt_d = err_cnt_q + CNT_W'(1);
        end
        if (!err_flag_q) begin
          err_flag_d  = 1'b1;
          first_err_d = {a, b, c, a1, b1, c1};
        end
`ifdef CSWAP_CHK_ERRMASK_EN
        err_mask_d = err_mask_q | combo_hot;
`endif
      end
      if ((cov_mask_d == 8'hFF) || ((STOP_ON_ERR != 0) && mismatch)) begin
        state_d = ST_DONE;
      end
    end

    // Status flags are registered copies of the next-state decode.
    busy_d = (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
    pass_d = done_d && (err_cnt_d == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      err_flag_q  <= 1'b0;
      vec_cnt_q   <= '0;
      err_cnt_q   <= '0;
      cov_mask_q  <= '0;
      first_err_q <= '0;
`ifdef CSWAP_CHK_ERRMASK_EN
      err_mask_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      err_flag_q  <= err_flag_d;
      vec_cnt_q   <= vec_cnt_d;
      err_cnt_q   <= err_cnt_d;
      cov_mask_q  <= cov_mask_d;
      first_err_q <= first_err_d;
`ifdef CSWAP_CHK_ERRMASK_EN
      err_mask_q  <= err_mask_d;
`endif
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_flag  = err_flag_q;
  assign vec_cnt   = vec_cnt_q;
  assign err_cnt   = err_cnt_q;
  assign cov_mask  = cov_mask_q;
  assign first_err = first_err_q;
`ifdef CSWAP_CHK_ERRMASK_EN
  assign err_mask  = err_mask_q;
`endif

endmodule

// File: tb/tb_cswap_checker.sv
// Scoreboard bench for cswap_checker: three instances (plain, stop-on-error, 4-bit counters)
// share stimulus; expected snapshots are queued and checked by a separate monitor.
module tb_cswap_checker;

  logic clk = 1'b0;
  logic rst, in_valid, a, b, c, a1, b1, c1;
  logic start_m, start_s, start_t;

  always #5 clk = ~clk;

  // Instance outputs: m = main (16/0), s = stop (16/1), t = saturation (4/0)
  logic        m_busy, m_done, m_pass, m_ef, s_busy, s_done, s_pass, s_ef;
  logic        t_busy, t_done, t_pass, t_ef;
  logic [15:0] m_vec, m_err, s_vec, s_err;
  logic [3:0]  t_vec, t_err;
  logic [7:0]  m_cov, s_cov, t_cov;
  logic [5:0]  m_fe, s_fe, t_fe;
`ifdef CSWAP_CHK_ERRMASK_EN
  logic [7:0]  m_em, s_em, t_em;
`endif

  cswap_checker #(.CNT_W(16), .STOP_ON_ERR(0)) u_main (
    .clk(clk), .rst(rst), .start(start_m), .in_valid(in_valid),
    .a(a), .b(b), .c(c), .a1(a1), .b1(b1), .c1(c1),
    .busy(m_busy), .done(m_done), .pass(m_pass), .err_flag(m_ef),
    .vec_cnt(m_vec), .err_cnt(m_err), .cov_mask(m_cov),
`ifdef CSWAP_CHK_ERRMASK_EN
    .err_mask(m_em),
`endif
    .first_err(m_fe)
  );

  cswap_checker #(.CNT_W(16), .STOP_ON_ERR(1)) u_stop (
    .clk(clk), .rst(rst), .start(start_s), .in_valid(in_valid),
    .a(a), .b(b), .c(c), .a1(a1), .b1(b1), .c1(c1),
    .busy(s_busy), .done(s_done), .pass(s_pass), .err_flag(s_ef),
    .vec_cnt(s_vec), .err_cnt(s_err), .cov_mask(s_cov),
`ifdef CSWAP_CHK_ERRMASK_EN
    .err_mask(s_em),
`endif
    .first_err(s_fe)
  );

  cswap_checker #(.CNT_W(4), .STOP_ON_ERR(0)) u_sat (
    .clk(clk), .rst(rst), .start(start_t), .in_valid(in_valid),
    .a(a), .b(b), .c(c), .a1(a1), .b1(b1), .c1(c1),
    .busy(t_busy), .done(t_done), .pass(t_pass), .err_flag(t_ef),
    .vec_cnt(t_vec), .err_cnt(t_err), .cov_mask(t_cov),
`ifdef CSWAP_CHK_ERRMASK_EN
    .err_mask(t_em),
`endif
    .first_err(t_fe)
  );

  typedef struct {
    string       name;
    int          sel;
    logic [57:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fails  = 0;

  // Snapshot layout: {busy, done, pass, err_flag, vec[16], err[16], cov[8], first_err[6], em[8]}
  function automatic logic [57:0] mk(input logic bz, input logic dn, input logic ps,
                                     input logic ef, input logic [15:0] vc,
                                     input logic [15:0] ec, input logic [7:0] cv,
                                     input logic [5:0] fe, input logic [7:0] em);
    logic [7:0] em_v;
    em_v = em;
`ifndef CSWAP_CHK_ERRMASK_EN
    em_v = 8'h00;
`endif
    return {bz, dn, ps, ef, vc, ec, cv, fe, em_v};
  endfunction

  function automatic logic [57:0] snap(input int sel);
    logic [7:0] em;
    em = 8'h00;
    if (sel == 0) begin
`ifdef CSWAP_CHK_ERRMASK_EN
      em = m_em;
`endif
      return {m_busy, m_done, m_pass, m_ef, m_vec, m_err, m_cov, m_fe, em};
    end else if (sel == 1) begin
`ifdef CSWAP_CHK_ERRMASK_EN
      em = s_em;
`endif
      return {s_busy, s_done, s_pass, s_ef, s_vec, s_err, s_cov, s_fe, em};
    end
`ifdef CSWAP_CHK_ERRMASK_EN
    em = t_em;
`endif
    return {t_busy, t_done, t_pass, t_ef, 12'h0, t_vec, 12'h0, t_err, t_cov, t_fe, em};
  endfunction

  function automatic logic [2:0] fred(input logic [2:0] abc);
    return abc[2] ? {1'b1, abc[0], abc[1]} : abc;
  endfunction

  // Monitor: compares every queued expectation against the DUT on the falling edge.
  initial begin
    exp_t        e;
    logic [57:0] act;
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        act = snap(e.sel);
        n_checks++;
        if (act !== e.val) begin
          n_fails++;
          $display("FAIL %s: got %h expected %h", e.name, act, e.val);
        end
      end
    end
  end

  task automatic expect_state(input string name, input int sel, input logic [57:0] v);
    exp_t e;
    e.name = name;
    e.sel  = sel;
    e.val  = v;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic v, input logic [2:0] abc, input logic [2:0] rsp);
    in_valid     = v;
    {a, b, c}    = abc;
    {a1, b1, c1} = rsp;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    logic [2:0] v3;
    {rst, in_valid, a, b, c, a1, b1, c1, start_m, start_s, start_t} = '0;
    #1;
    do_reset();
    expect_state("reset_main", 0, mk(0, 0, 0, 0, 0, 0, 8'h00, 6'h00, 8'h00));
    expect_state("reset_sat", 2, mk(0, 0, 0, 0, 0, 0, 8'h00, 6'h00, 8'h00));

    // Vectors shown with in_valid in IDLE are ignored.
    send(1'b1, 3'b001, 3'b111);
    expect_state("idle_ignores", 0, mk(0, 0, 0, 0, 0, 0, 8'h00, 6'h00, 8'h00));

    // Start with a valid vector on the same edge: vector not counted.
    start_m = 1'b1;
    send(1'b1, 3'b000, 3'b000);
    start_m = 1'b0;
    expect_state("start_idle_vec", 0, mk(1, 0, 0, 0, 0, 0, 8'h00, 6'h00, 8'h00));

    // Clean exhaustive run.
    for (int i = 0; i < 8; i++) begin
      v3 = 3'(i);
      send(1'b1, v3, fred(v3));
      if (i == 6) expect_state("clean_7", 0, mk(1, 0, 0, 0, 7, 0, 8'h7F, 6'h00, 8'h00));
    end
    expect_state("clean_done", 0, mk(0, 1, 1, 0, 8, 0, 8'hFF, 6'h00, 8'h00));
    send(1'b1, 3'b010, 3'b111);
    expect_state("done_holds", 0, mk(0, 1, 1, 0, 8, 0, 8'hFF, 6'h00, 8'h00));

    // Restart from DONE with a concurrent valid vector.
    start_m = 1'b1;
    send(1'b1, 3'b001, 3'b001);
    start_m = 1'b0;
    expect_state("restart_clear", 0, mk(1, 0, 0, 0, 0, 0, 8'h00, 6'h00, 8'h00));

    // Single fault: 101 answered with 101 instead of 110.
    for (int i = 0; i < 8; i++) begin
      v3 = 3'(i);
      send(1'b1, v3, (i == 5) ? 3'b101 : fred(v3));
      if (i == 5) expect_state("fault_6", 0, mk(1, 0, 0, 1, 6, 1, 8'h3F, 6'b101101, 8'h20));
    end
    expect_state("fault_done", 0, mk(0, 1, 0, 1, 8, 1, 8'hFF, 6'b101101, 8'h20));

    // Gaps and duplicates; gap cycles carry wrong responses that must be ignored.
    start_m = 1'b1;
    tick();
    start_m = 1'b0;
    for (int i = 0; i < 3; i++) begin
      send(1'b1, 3'b000, 3'b000);
      send(1'b0, 3'b100, 3'b000);
    end
    expect_state("dup_3", 0, mk(1, 0, 0, 0, 3, 0, 8'h01, 6'h00, 8'h00));
    for (int i = 1; i < 8; i++) begin
      v3 = 3'(i);
      send(1'b1, v3, fred(v3));
      send(1'b0, v3, ~fred(v3));
    end
    expect_state("dup_done", 0, mk(0, 1, 1, 0, 10, 0, 8'hFF, 6'h00, 8'h00));

    // Reset mid-run after 4 vectors; reset also beats a concurrent start.
    start_m = 1'b1;
    tick();
    start_m = 1'b0;
    for (int i = 0; i < 4; i++) begin
      v3 = 3'(i);
      send(1'b1, v3, fred(v3));
    end
    expect_state("mid_4", 0, mk(1, 0, 0, 0, 4, 0, 8'h0F, 6'h00, 8'h00));
    rst     = 1'b1;
    start_m = 1'b1;
    send(1'b1, 3'b100, 3'b110);
    rst     = 1'b0;
    start_m = 1'b0;
    expect_state("mid_reset", 0, mk(0, 0, 0, 0, 0, 0, 8'h00, 6'h00, 8'h00));

    // Stop-on-error: 011 answered with 010.
    start_s = 1'b1;
    tick();
    start_s = 1'b0;
    send(1'b1, 3'b011, 3'b010);
    expect_state("stop_done", 1, mk(0, 1, 0, 1, 1, 1, 8'h08, 6'b011010, 8'h08));
    send(1'b1, 3'b100, 3'b110);
    expect_state("stop_holds", 1, mk(0, 1, 0, 1, 1, 1, 8'h08, 6'b011010, 8'h08));

    // Saturation at 4 bits with 20 mismatching copies of 000.
    do_reset();
    start_t = 1'b1;
    tick();
    start_t = 1'b0;
    for (int i = 0; i < 20; i++) begin
      send(1'b1, 3'b000, 3'b111);
      if (i == 14) expect_state("sat_15", 2, mk(1, 0, 0, 1, 15, 15, 8'h01, 6'b000111, 8'h01));
    end
    expect_state("sat_hold", 2, mk(1, 0, 0, 1, 15, 15, 8'h01, 6'b000111, 8'h01));

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) tick();
    if (exp_q.size() > 0) begin
      n_fails++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/cswap_checker.md
Name: cswap_checker

Overview:
- Synthesizable response checker for the 3-bit Fredkin controlled-swap gate.
- It receives stimulus/response pairs and computes the expected Fredkin outputs:
  - A1 = A.
  - A=0: B1=B, C1=C.
  - A=1: B1=C, C1=B.
- It compares the expected outputs with the observed outputs and keeps vector and error counts plus an input-combination coverage mask.
- It flags done/pass once all 8 input combinations have been seen. It sits on the receiving side of the DUT outputs in on-chip self-test harnesses.

Parameters:
- CNT_W, 16, width of vector and error counters (min 4).
- STOP_ON_ERR, 0, when 1 the checker ends a run on the first mismatch.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse; begins a run and clears all results.
- in_valid  input  1  the stimulus/response triple is valid this cycle.
- a  input  1  stimulus A (control).
- b  input  1  stimulus B.
- c  input  1  stimulus C.
- a1  input  1  observed DUT output A1.
- b1  input  1  observed DUT output B1.
- c1  input  1  observed DUT output C1.
- busy  output  1  high while in RUN.
- done  output  1  high in DONE.
- pass  output  1  done and err_cnt==0.
- err_flag  output  1  sticky; set on the first mismatch of the run.
- vec_cnt  output  CNT_W  vectors accepted this run (saturating).
- err_cnt  output  CNT_W  mismatches this run (saturating).
- cov_mask  output  8  bit {a,b,c} set once that input combination has been accepted.
- first_err  output  6  {a,b,c,a1,b1,c1} of the first mismatching vector; 0 if none.

Behaviour:
- Reset (rst=1 at edge): state=IDLE; busy=0, done=0, pass=0, err_flag=0, vec_cnt=0, err_cnt=0, cov_mask=0, first_err=0. Reset wins over every other input. Reset mid-run aborts the run with no residue.
- States:
  - IDLE: in_valid is ignored.
  - RUN: a vector is accepted on any edge with in_valid=1.
  - DONE: all results hold and in_valid is ignored.
- Transitions:
  - IDLE -> RUN on start. All results are cleared on the same edge.
  - RUN -> DONE on the edge where cov_mask becomes 8'hFF, including the accepting vector.
  - RUN -> DONE on the edge where a mismatch is accepted, if STOP_ON_ERR=1.
  - DONE -> RUN on start, clearing all results.
  - start during RUN is ignored.
- Accept edge (RUN, in_valid=1):
  - Compute exp = {a, a?c:b, a?b:c}; mismatch when {a1,b1,c1} != exp.
  - vec_cnt += 1, saturating at 2^CNT_W-1.
  - cov_mask[{a,b,c}] = 1.
  - On mismatch:
    - err_cnt += 1, saturating.
    - If err_flag was 0, set err_flag=1 and load first_err.
- Latency: all outputs are registered; the effect of a vector accepted at edge N is visible after edge N.
- Simultaneous events:
  - If the vector that completes coverage also mismatches, it is counted as an error. State goes to DONE and pass=0.
  - If start and in_valid arrive in the same cycle in IDLE or DONE, the vector is NOT accepted, because results clear on that edge.
- pass is registered and equal to (next state==DONE && next err_cnt==0). It is 0 outside DONE.
- Duplicate vectors are counted normally. Coverage is an OR-accumulation.

Optional Feature:
- Macro: CSWAP_CHK_ERRMASK_EN.
- Defined:
  - Adds output port err_mask (8 bits).
  - Bit {a,b,c} is set when a mismatch is accepted for that input combination.
  - It is cleared on reset and on start, and holds in DONE.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Clean exhaustive run:
  - Stimulus: reset, start, then the 8 vectors abc=000..111 with correct Fredkin responses, one per cycle.
  - Response: DONE after the 8th edge, cov_mask=FF, vec_cnt=8, err_cnt=0, pass=1, err_flag=0, first_err=0.
- Single fault:
  - Stimulus: same as the clean run, but abc=101 is answered with a1b1c1=101 (expected 110).
  - Response: err_cnt=1, err_flag=1, first_err=6'b101101, pass=0, DONE after 8 vectors.
  - With the macro defined: err_mask=8'b0010_0000.
- STOP_ON_ERR=1:
  - Stimulus: the first vector is abc=011 answered with 010.
  - Response: DONE on that edge, vec_cnt=1, err_cnt=1, cov_mask=8'b0000_1000, pass=0.
- Handshake gaps and duplicates:
  - Stimulus: in_valid toggled 1/0, with vector 000 sent 3 times before the remaining 7.
  - Response: vec_cnt=10 at DONE.
  - Vectors presented with in_valid=0, or while in IDLE or DONE, change nothing.
- Restart and reset:
  - Stimulus: start in DONE with in_valid=1 on the same cycle.
  - Response: all results 0 and state RUN; the vector is not counted.
  - Stimulus: rst pulsed after 4 accepted vectors.
  - Response: everything 0 and IDLE the next cycle.
- Saturation:
  - Stimulus: CNT_W=4, 20 mismatching copies of vector 000.
  - Response: vec_cnt=15 and err_cnt=15, held; no wrap to 0.
